// File: rtl/apb_master_ctrl_1.sv
// APB master controller for the axi2apb_1 bridge.
// Takes one request at a time, samples the decoder's one-hot select, runs the
// APB SETUP/ACCESS sequence on that slave and returns a response. Decode
// misses and hung slaves (timeout) are answered locally.
module apb_master_ctrl_1 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLAVE_NUM      = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    // request channel
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic                            req_write,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    input  logic [DATA_WIDTH/8-1:0]         req_strb,
    input  logic [2:0]                      req_prot,
    // address decoder
    output logic [ADDR_WIDTH-1:0]           dec_addr,
    input  logic [SLAVE_NUM-1:0]            ss,
    // response channel
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_slverr,
    output logic                            rsp_decerr,
    // APB master
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic                            pwrite,
    output logic [DATA_WIDTH-1:0]           pwdata,
    output logic [DATA_WIDTH/8-1:0]         pstrb,
    output logic [2:0]                      pprot,
    output logic [SLAVE_NUM-1:0]            psel,
    output logic                            penable,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] prdata,
    input  logic [SLAVE_NUM-1:0]            pready,
    input  logic [SLAVE_NUM-1:0]            pslverr
);

    localparam int TMO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter value on the last ACCESS cycle allowed before a forced error.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state_q, state_d;
    logic [SLAVE_NUM-1:0]   sel_q;
    logic [SLAVE_NUM-1:0]   ss_low;
    logic [TMO_WIDTH-1:0]   tmo_cnt;
    logic                   accept, miss, complete, timeout;
    logic                   sel_ready, sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;

    // The decoder sees the live request address.
    assign dec_addr = req_addr;

    // Isolate the lowest set bit so a multi-hot select still picks one slave.
    assign ss_low = ss & (~ss + SLAVE_NUM'(1));

    // Gather ready/error/data from the captured slave only.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (sel_q[i]) begin
                sel_ready = sel_ready | pready[i];
                sel_err   = sel_err | pslverr[i];
                sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), not in the sensitivity list.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and one-cycle event strobes for the datapath.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        miss     = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (ss == '0) begin
                        miss    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A completing slave takes priority over an expiring timer.
                if (sel_ready) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, captured request and the ACCESS timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            rsp_decerr <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
            psel       <= '0;
            penable    <= 1'b0;
            sel_q      <= '0;
            tmo_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            req_ready <= (state_d == IDLE);
            penable   <= (state_d == ACCESS);
            tmo_cnt   <= (state_q == ACCESS) ? tmo_cnt + TMO_WIDTH'(1) : '0;

            if (state_d == SETUP)       psel <= ss_low;
            else if (state_d == ACCESS) psel <= sel_q;
            else                        psel <= '0;

            if (accept) begin
                sel_q  <= ss_low;
                paddr  <= req_addr;
                pwrite <= req_write;
                pwdata <= req_wdata;
                pstrb  <= req_write ? req_strb : '0;
                pprot  <= req_prot;
            end

            if (miss) begin
                rsp_valid  <= 1'b1;
                rsp_decerr <= 1'b1;
                rsp_slverr <= 1'b0;
                rsp_rdata  <= '0;
            end else if (complete) begin
                rsp_valid  <= 1'b1;
                rsp_decerr <= 1'b0;
                rsp_slverr <= sel_err;
                rsp_rdata  <= (!pwrite && !sel_err) ? sel_rdata : '0;
            end else if (timeout) begin
                rsp_valid  <= 1'b1;
                rsp_decerr <= 1'b0;
                rsp_slverr <= 1'b1;
                rsp_rdata  <= '0;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl_1.sv
// Scoreboard bench for apb_master_ctrl_1: the driver pushes the expected
// response (data, flags, latency) when a request is accepted; independent
// monitors check the APB bus and pop/compare responses.
module tb_apb_master_ctrl_1;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int SN  = 5;
    localparam int TMO = 4;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          decerr;
        int            lat;
        int            acc_cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [AW-1:0]     req_addr, dec_addr, paddr;
    logic [DW-1:0]     req_wdata, rsp_rdata, pwdata;
    logic [SW-1:0]     req_strb, pstrb;
    logic [2:0]        req_prot, pprot;
    logic [SN-1:0]     ss, psel, pready, pslverr;
    logic              rsp_valid, rsp_ready, rsp_slverr, rsp_decerr;
    logic              pwrite, penable;
    logic [SN*DW-1:0]  prdata;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    // Expected APB bundle and slave behaviour for the transaction in flight.
    logic [SN-1:0] exp_psel;
    logic [AW-1:0] exp_paddr;
    logic          exp_pwrite;
    logic [DW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic [2:0]    exp_pprot;
    int            cur_idx = -1;
    int            cur_delay = 0;
    logic          cur_err = 1'b0;
    logic [DW-1:0] cur_rd = '0;
    int            hold_cfg = -1;

    apb_master_ctrl_1 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_NUM(SN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .dec_addr(dec_addr), .ss(ss),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_decerr(rsp_decerr),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pprot(pprot), .psel(psel), .penable(penable), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one request (called at a negedge) and push its expected response.
    task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input logic [2:0] prot, input logic [SN-1:0] ssv,
                         input int dly, input logic err, input logic [DW-1:0] rd);
        int   idx;
        int   guard;
        exp_t e;
        guard = 0;
        while (!req_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("req_ready_wait", req_ready, 1);
            return;
        end
        idx = -1;
        for (int i = 0; i < SN; i++) if (ssv[i] && idx < 0) idx = i;
        exp_psel   = (idx < 0) ? '0 : SN'(1 << idx);
        exp_paddr  = addr;
        exp_pwrite = wr;
        exp_pwdata = wdata;
        exp_pstrb  = wr ? strb : '0;
        exp_pprot  = prot;
        cur_idx    = idx;
        cur_delay  = dly;
        cur_err    = err;
        cur_rd     = rd;
        req_addr   = addr;
        req_write  = wr;
        req_wdata  = wdata;
        req_strb   = strb;
        req_prot   = prot;
        ss         = ssv;
        req_valid  = 1'b1;
        if (idx < 0) begin
            e.decerr = 1'b1; e.slverr = 1'b0; e.rdata = '0; e.lat = 1;
        end else if (dly <= TMO - 1) begin
            e.decerr = 1'b0; e.slverr = err; e.rdata = (!wr && !err) ? rd : '0; e.lat = 2 + dly + 1;
        end else begin
            e.decerr = 1'b0; e.slverr = 1'b1; e.rdata = '0; e.lat = 2 + TMO;
        end
        e.acc_cyc = cyc;
        sb.push_back(e);
        #1 check("dec_addr", dec_addr, addr);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        ss        = SN'($urandom);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Slave model: selected slave answers after cur_delay ACCESS cycles; others babble.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        pready = '0; pslverr = '0; prdata = '0;
        forever begin
            @(negedge clk);
            pready  = SN'($urandom);
            pslverr = SN'($urandom);
            for (int i = 0; i < SN; i++) prdata[i*DW +: DW] = $urandom;
            if (penable) begin
                if (cur_idx >= 0) begin
                    pready[cur_idx]           = (acc_cnt == cur_delay);
                    pslverr[cur_idx]          = cur_err;
                    prdata[cur_idx*DW +: DW]  = cur_rd;
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
            end
        end
    end

    // APB monitor: bundle matches the request, SETUP precedes ACCESS, no accepts meanwhile.
    initial begin
        logic [SN-1:0] prev_psel;
        prev_psel = '0;
        forever begin
            @(negedge clk);
            if (!rst && (psel != '0 || penable)) begin
                check("apb_psel", psel, exp_psel);
                check("apb_penable", penable, prev_psel != '0);
                check("apb_paddr", paddr, exp_paddr);
                check("apb_pwrite", pwrite, exp_pwrite);
                check("apb_pwdata", pwdata, exp_pwdata);
                check("apb_pstrb", pstrb, exp_pstrb);
                check("apb_pprot", pprot, exp_pprot);
                check("req_ready_busy", req_ready, 0);
            end
            prev_psel = psel;
        end
    end

    // Response monitor: compares against the scoreboard head and drives rsp_ready.
    initial begin
        exp_t e;
        int   wait_left;
        logic in_resp;
        logic rr_next;
        in_resp = 1'b0;
        rr_next = 1'b0;
        wait_left = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_ready = 1'b0;
                in_resp   = 1'b0;
                rr_next   = 1'b0;
            end else begin
                if (rr_next) begin
                    check("req_ready_after_rsp", req_ready, 1);
                    rr_next = 1'b0;
                end
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected_valid", rsp_valid, 0);
                        rsp_ready = 1'b1;
                    end else begin
                        e = sb[0];
                        if (!in_resp) begin
                            in_resp   = 1'b1;
                            wait_left = (hold_cfg >= 0) ? hold_cfg : $urandom_range(0, 2);
                            check("rsp_latency", cyc - e.acc_cyc, e.lat);
                        end
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_slverr", rsp_slverr, e.slverr);
                        check("rsp_decerr", rsp_decerr, e.decerr);
                        check("apb_idle_in_resp", {psel, penable}, 0);
                        check("req_ready_in_resp", req_ready, 0);
                        if (wait_left == 0) begin
                            rsp_ready = 1'b1;
                            void'(sb.pop_front());
                            in_resp = 1'b0;
                            rr_next = 1'b1;
                        end else begin
                            rsp_ready = 1'b0;
                            wait_left--;
                        end
                    end
                end else begin
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        int           guard;
        logic [SN-1:0] ssv;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        req_strb = '0; req_prot = '0; ss = '0;
        exp_psel = '0; exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0;
        exp_pstrb = '0; exp_pprot = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp", {rsp_valid, rsp_slverr, rsp_decerr}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_psel_penable", {psel, penable}, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pctl", {pwrite, pstrb, pprot}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);

        // Minimum-latency read from slave 1.
        issue(32'h0005_0010, 1'b0, 32'h0, 4'hF, 3'b000, 5'b00010, 0, 1'b0, 32'hCAFE_BABE);
        // Write to slave 4 with three wait states (pready on the last legal cycle).
        issue(32'h0008_0004, 1'b1, 32'h1234_5678, 4'hF, 3'b010, 5'b10000, 3, 1'b0, 32'hDEAD_BEEF);
        // Decode miss.
        issue(32'h0010_0000, 1'b0, 32'h0, 4'h0, 3'b001, 5'b00000, 0, 1'b0, 32'h0);
        // Slave 0 never ready: timeout.
        issue(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000, 5'b00001, 1000, 1'b0, 32'h5555_AAAA);
        // Multi-hot select: lowest index (slave 2) wins.
        issue(32'h0003_0008, 1'b0, 32'h0, 4'h3, 3'b100, 5'b10100, 1, 1'b0, 32'h0BAD_F00D);
        wait_drain();
        // Slave 2 error with a stalled response channel.
        hold_cfg = 5;
        issue(32'h0002_0000, 1'b0, 32'h0, 4'h0, 3'b000, 5'b00100, 1, 1'b1, 32'h7777_7777);
        wait_drain();
        hold_cfg = -1;

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ssv = ($urandom_range(0, 4) == 0) ? '0 : SN'($urandom);
            issue($urandom, 1'($urandom_range(0, 1)), $urandom, SW'($urandom), 3'($urandom), ssv,
                  $urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom);
        end
        wait_drain();

        // Reset in the middle of ACCESS abandons the transfer.
        issue(32'h0000_2000, 1'b0, 32'h0, 4'h0, 3'b000, 5'b00001, 1000, 1'b0, 32'h0);
        guard = 0;
        while (!penable && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("reset_test_in_access", penable, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_psel_penable", {psel, penable}, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        issue(32'h0004_0100, 1'b0, 32'h0, 4'h0, 3'b000, 5'b01000, 2, 1'b0, 32'h1357_9BDF);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl_1.md
Name: apb_master_ctrl_1

Overview:
APB master state machine of the axi2apb_1 bridge, sitting directly downstream of the APB address decoder.
- Accepts one request at a time from the bridge front-end over a valid/ready channel.
- Presents the request address to the decoder and samples the decoder's one-hot slave select.
- Runs the APB SETUP/ACCESS sequence on the selected slave, then returns read data and error status over a valid/ready response channel.
- Handles decode misses (no slave selected) and slave hang (timeout) locally.

Parameters:
ADDR_WIDTH, 32, request/APB address width
DATA_WIDTH, 32, data width; multiple of 8
SLAVE_NUM, 5, number of APB slaves (width of ss/psel)
TIMEOUT_CYCLES, 256, max ACCESS cycles before forced error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_addr  in  ADDR_WIDTH  request address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  write strobes
req_prot  in  3  protection attributes
dec_addr  out  ADDR_WIDTH  address to decoder; combinational copy of req_addr
ss  in  SLAVE_NUM  one-hot select from decoder for dec_addr
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_slverr  out  1  slave error or timeout
rsp_decerr  out  1  no slave decoded
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes; 0 on reads
pprot  out  3  APB protection
psel  out  SLAVE_NUM  per-slave select, at most one bit set
penable  out  1  APB enable
prdata  in  SLAVE_NUM*DATA_WIDTH  slave i read data at [i*DATA_WIDTH +: DATA_WIDTH]
pready  in  SLAVE_NUM  per-slave ready
pslverr  in  SLAVE_NUM  per-slave error

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset: at any clk edge with rst=1, the block enters IDLE and all registered outputs clear to 0.
  - This covers req_ready, rsp_*, paddr, pwrite, pwdata, pstrb, pprot, psel and penable.
  - Reset mid-transfer abandons the transfer with no response; psel/penable are 0 in the cycle after the reset edge.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, capture addr/write/wdata/strb/prot and sample ss into sel_q.
  - If ss has several bits set, the lowest index wins.
  - ss==0: go to RESP with rsp_decerr=1, rsp_slverr=0, rsp_rdata=0; no APB activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - psel=sel_q, penable=0.
  - paddr/pwrite/pwdata/pprot driven from captured values; pstrb=captured strb for writes, 0 for reads.
  - Always go to ACCESS.
- ACCESS:
  - psel held, penable=1. All APB outputs are stable from SETUP through the end of ACCESS.
  - Selected slave's pready=1: capture prdata (reads only), set rsp_slverr=pslverr[sel], then go to RESP.
  - Timeout counter: cleared on entry, increments each ACCESS cycle without pready.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with pready still 0, go to RESP with rsp_slverr=1 and rsp_rdata=0.
  - pready and timeout in the same cycle: the pready completion wins.
- Leaving ACCESS: psel=0 and penable=0 on the next cycle.
- RESP:
  - rsp_valid=1; rsp fields held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE; req_ready=1 in the following cycle.
  - req_ready=0 in SETUP, ACCESS and RESP.
- Timing (minimum transaction):
  - Accept at T, SETUP at T+1, ACCESS at T+2.
  - With pready at T+2, rsp_valid=1 at T+3.
  - With rsp_ready at T+3, IDLE at T+4.
- Decode-miss latency: accept at T, rsp_valid=1 at T+1.
- Unselected slaves: pready/pslverr/prdata ignored.

Test Plan:
- Read at 0x00050010, ss=5'b00010, slave1 pready=1 immediately, prdata=0xCAFEBABE -> psel=00010 at T+1, penable=1 at T+2, rsp_valid at T+3 with rdata=0xCAFEBABE, slverr=0, decerr=0.
- Write 0x00080004, wdata=0x12345678, strb=4'hF, slave4 pready low 3 cycles -> psel=10000 and pwdata/paddr stable for the 4 ACCESS cycles; rsp_valid one cycle after pready; rdata=0.
- Address 0x00100000, ss=0 -> rsp_valid at T+1 with decerr=1; psel stays 0 throughout.
- TIMEOUT_CYCLES=4, slave0 never ready -> after 4 ACCESS cycles, rsp_slverr=1, rdata=0; psel drops the next cycle.
- slave2 completes with pslverr=1; rsp_ready held low 5 cycles -> rsp_valid and slverr held stable 5 cycles; req_ready=0 until the cycle after the rsp handshake.
- rst=1 during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, req_ready=0; after rst drops, IDLE with req_ready=1 and the next request completes normally.
